// File: rtl/ezm_seq_pkg.sv
// Shared types and constants for the EZM core program sequencer.
// Opcode field constants are used when assembling programs for the core.
package ezm_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DRAIN_F,
      S_DRAIN_E,
      S_DONE
   } state_e;

   localparam logic [1:0] ST_END     = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;
   localparam logic [1:0] ST_HALT    = 2'b10;

   localparam logic [5:0] OP_NOP    = 6'b000000;
   localparam logic [5:0] OP_LOAD   = 6'b100000;
   localparam logic [5:0] OP_BRANCH = 6'b011000;
   localparam logic [5:0] OP_STORE  = 6'b001000;
   localparam logic [5:0] OP_ADD    = 6'b010000;
   localparam logic [5:0] OP_NEG    = 6'b000001;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ezm_prog_mem.sv
// Program store: synchronous write, combinational read.
// Contents are deliberately not reset.
module ezm_prog_mem #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned IW    = 6,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [IW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [IW-1:0] rdata
);

   logic [IW-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/ezm_cpu_sequencer.sv
// Sequencer for the two-phase EZM accumulator core: feeds instruction words by
// PC, stops on program end / budget / halt, then drains the accumulator.
module ezm_cpu_sequencer
   import ezm_seq_pkg::*;
#(
   parameter  int unsigned DEPTH     = 32,
   parameter  int unsigned IW        = 6,
   parameter  int unsigned DW        = 8,
   parameter  int unsigned MAX_INSTR = 255,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          prog_we,
   input  logic [AW-1:0] prog_addr,
   input  logic [IW-1:0] prog_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
   input  logic          halt_req,
   input  logic [DW-1:0] cpu_out,
   output logic [IW-1:0] cpu_in,
   output logic          cpu_rst,
   output logic          busy,
   output logic          done,
   output logic [1:0]    status,
   output logic [DW-1:0] acc_q,
   output logic [7:0]    instr_cnt
);

   state_e        state_q, state_d;
   logic [AW:0]   len_q, len_d;
   logic [IW-1:0] ir_q, ir_d;
   logic [7:0]    cnt_q, cnt_d;
   logic [1:0]    status_q, status_d;
   logic [DW-1:0] acc_d;
   logic          halt_pend_q, halt_pend_d;
   logic          busy_q, busy_d;
   logic          cpu_rst_q, cpu_rst_d;
   logic          done_q, done_d;
   logic [IW-1:0] mem_rdata;

   ezm_prog_mem #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) u_mem (
      .clk   (clk),
      .we    (prog_we && !busy_q),
      .waddr (prog_addr),
      .wdata (prog_data),
      .raddr (cpu_out[AW-1:0]),
      .rdata (mem_rdata)
   );

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      ir_d        = ir_q;
      cnt_d       = cnt_q;
      status_d    = status_q;
      acc_d       = acc_q;
      busy_d      = busy_q;
      cpu_rst_d   = cpu_rst_q;
      done_d      = done_q;
      cpu_in      = IW'(OP_NOP);
      halt_pend_d = halt_pend_q || (busy_q && halt_req);
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               len_d     = prog_len;
               cnt_d     = '0;
               status_d  = ST_END;
               busy_d    = 1'b1;
               cpu_rst_d = 1'b0;
               state_d   = (prog_len == '0) ? S_DRAIN_F : S_FETCH;
            end
         end
         S_FETCH: begin
            ir_d = mem_rdata;
            // End checks are evaluated before the fetched word is issued.
            if (32'(cpu_out) >= 32'(len_q)) begin
               status_d = ST_END;
               state_d  = S_DRAIN_E;
            end else if (cnt_q == 8'(MAX_INSTR)) begin
               status_d = ST_TIMEOUT;
               state_d  = S_DRAIN_E;
            end else if (halt_pend_q) begin
               status_d = ST_HALT;
               state_d  = S_DRAIN_E;
            end else begin
               cpu_in  = mem_rdata;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            cpu_in  = ir_q;
            cnt_d   = sat_inc8(cnt_q);
            state_d = S_FETCH;
         end
         S_DRAIN_F: state_d = S_DRAIN_E;
         S_DRAIN_E: begin
            acc_d     = cpu_out;
            busy_d    = 1'b0;
            cpu_rst_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_DONE;
         end
         S_DONE: begin
            done_d      = 1'b0;
            halt_pend_d = 1'b0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         ir_q        <= '0;
         cnt_q       <= '0;
         status_q    <= ST_END;
         acc_q       <= '0;
         halt_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         cpu_rst_q   <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         ir_q        <= ir_d;
         cnt_q       <= cnt_d;
         status_q    <= status_d;
         acc_q       <= acc_d;
         halt_pend_q <= halt_pend_d;
         busy_q      <= busy_d;
         cpu_rst_q   <= cpu_rst_d;
         done_q      <= done_d;
      end
   end

   assign cpu_rst   = cpu_rst_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign status    = status_q;
   assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_ezm_cpu_sequencer.sv
// Bench for ezm_cpu_sequencer: two instances (budget 16 and 255) driving an ISA-level
// core model, checked per cycle against a trace predicted by a program interpreter.
module tb_ezm_cpu_sequencer;
   import ezm_seq_pkg::*;

   localparam int DEPTH = 32;

   typedef struct packed {
      logic [7:0]      pc;
      logic [7:0]      acc;
      logic [7:0][7:0] r;
   } cst_t;

   typedef struct packed {
      logic [5:0] cin;
      logic       busy;
      logic       crst;
      logic       done;
      logic [1:0] st;
      logic [7:0] acc;
      logic [7:0] cnt;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst, prog_we, start, halt_req;
   logic [4:0] prog_addr;
   logic [5:0] prog_data, prog_len;
   logic [7:0] cpu_out [2];
   logic [5:0] cpu_in [2];
   logic       cpu_rst [2], busy [2], done [2];
   logic [1:0] status [2];
   logic [7:0] acc_q [2], instr_cnt [2];

   cst_t       cs [2];
   logic       ph [2];
   logic [5:0] img [DEPTH];
   ent_t       tr [2][1024];
   int         tr_len [2], tr_pos [2];
   logic [1:0] fin_st [2];
   logic [7:0] fin_acc [2], fin_cnt [2];
   int         halt_at;
   bit         edge_seen = 1'b0;
   bit         to_flag;
   bit         lit_en;
   logic [1:0] lit_st [2];
   logic [7:0] lit_acc [2], lit_cnt [2];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   ezm_cpu_sequencer #(.DEPTH(32), .IW(6), .DW(8), .MAX_INSTR(16)) u_dut16 (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_len(prog_len), .start(start), .halt_req(halt_req), .cpu_out(cpu_out[0]),
      .cpu_in(cpu_in[0]), .cpu_rst(cpu_rst[0]), .busy(busy[0]), .done(done[0]),
      .status(status[0]), .acc_q(acc_q[0]), .instr_cnt(instr_cnt[0]));

   ezm_cpu_sequencer #(.DEPTH(32), .IW(6), .DW(8), .MAX_INSTR(255)) u_dut255 (
      .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .prog_len(prog_len), .start(start), .halt_req(halt_req), .cpu_out(cpu_out[1]),
      .cpu_in(cpu_in[1]), .cpu_rst(cpu_rst[1]), .busy(busy[1]), .done(done[1]),
      .status(status[1]), .acc_q(acc_q[1]), .instr_cnt(instr_cnt[1]));

   // ISA: 1iiiii load imm, 011rrr jump to r, 001rrr store, 010rrr add, 000001 invert.
   function automatic cst_t isa_step(input cst_t s, input logic [5:0] ins);
      cst_t n = s;
      n.pc = s.pc + 8'd1;
      if (ins[5])                   n.acc = {3'b000, ins[4:0]};
      else if (ins[5:3] == 3'b011)  n.pc = s.r[ins[2:0]];
      else if (ins[5:3] == 3'b001)  n.r[ins[2:0]] = s.acc;
      else if (ins[5:3] == 3'b010)  n.acc = s.acc + s.r[ins[2:0]];
      else if (ins == OP_NEG)       n.acc = ~s.acc;
      return n;
   endfunction

   always @(posedge clk)
      for (int i = 0; i < 2; i++)
         if (cpu_rst[i]) begin
            cs[i] <= '0;
            ph[i] <= 1'b0;
         end else begin
            ph[i] <= ~ph[i];
            if (ph[i]) cs[i] <= isa_step(cs[i], cpu_in[i]);
         end

   assign cpu_out[0] = ph[0] ? cs[0].acc : cs[0].pc;
   assign cpu_out[1] = ph[1] ? cs[1].acc : cs[1].pc;

   function automatic ent_t mk(input logic [5:0] cin, input logic b, input logic r, input logic d,
                               input logic [1:0] st, input logic [7:0] acc, input logic [7:0] cnt);
      ent_t e;
      e.cin = cin; e.busy = b; e.crst = r; e.done = d; e.st = st; e.acc = acc; e.cnt = cnt;
      return e;
   endfunction

   // Interpret the program and lay out the expected per-cycle outputs of one run.
   task automatic build(input int i, input int len, input int maxi);
      cst_t       s = '0;
      int         n = 0;
      int         k = 0;
      logic [1:0] st;
      logic [5:0] ins;
      while (1) begin
         if (int'(s.pc) >= len) begin st = ST_END; break; end
         if (n == maxi) begin st = ST_TIMEOUT; break; end
         if (halt_at >= 0 && n > halt_at) begin st = ST_HALT; break; end
         ins = img[s.pc[4:0]];
         tr[i][k]   = mk(ins, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
         tr[i][k+1] = mk(ins, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
         k += 2;
         s = isa_step(s, ins);
         n++;
      end
      tr[i][k]   = mk(OP_NOP, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      tr[i][k+1] = mk(OP_NOP, 1'b1, 1'b0, 1'b0, 2'b00, 8'h00, 8'h00);
      tr[i][k+2] = mk(OP_NOP, 1'b0, 1'b1, 1'b1, st, s.acc, 8'(n));
      tr_len[i] = k + 3;
      tr_pos[i] = 0;
   endtask

   always @(posedge clk) begin
      edge_seen = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            tr_len[i] = 0; tr_pos[i] = 0;
            fin_st[i] = 2'b00; fin_acc[i] = 8'h00; fin_cnt[i] = 8'h00;
         end else if (tr_pos[i] < tr_len[i]) begin
            if (tr[i][tr_pos[i]].done) begin
               fin_st[i]  = tr[i][tr_pos[i]].st;
               fin_acc[i] = tr[i][tr_pos[i]].acc;
               fin_cnt[i] = tr[i][tr_pos[i]].cnt;
            end
            tr_pos[i]++;
         end else if (start) begin
            build(i, int'(prog_len), (i == 0) ? 16 : 255);
         end
      end
   end

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, i, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      ent_t e;
      if (edge_seen) begin
         chk("wait_bound", 0, 32'(to_flag), 32'd0);
         for (int i = 0; i < 2; i++) begin
            if (tr_pos[i] < tr_len[i]) begin
               e = tr[i][tr_pos[i]];
               chk("cpu_in", i, 32'(cpu_in[i]), 32'(e.cin));
               chk("busy", i, 32'(busy[i]), 32'(e.busy));
               chk("cpu_rst", i, 32'(cpu_rst[i]), 32'(e.crst));
               chk("done", i, 32'(done[i]), 32'(e.done));
               if (e.done) begin
                  chk("status", i, 32'(status[i]), 32'(e.st));
                  chk("acc_q", i, 32'(acc_q[i]), 32'(e.acc));
                  chk("instr_cnt", i, 32'(instr_cnt[i]), 32'(e.cnt));
                  if (lit_en) begin
                     chk("lit_status", i, 32'(status[i]), 32'(lit_st[i]));
                     chk("lit_acc", i, 32'(acc_q[i]), 32'(lit_acc[i]));
                     chk("lit_cnt", i, 32'(instr_cnt[i]), 32'(lit_cnt[i]));
                     chk("model_acc", i, 32'(e.acc), 32'(lit_acc[i]));
                     chk("model_status", i, 32'(e.st), 32'(lit_st[i]));
                     chk("model_cnt", i, 32'(e.cnt), 32'(lit_cnt[i]));
                  end
               end
            end else begin
               chk("idle_cpu_in", i, 32'(cpu_in[i]), 32'd0);
               chk("idle_busy", i, 32'(busy[i]), 32'd0);
               chk("idle_cpu_rst", i, 32'(cpu_rst[i]), 32'd1);
               chk("idle_done", i, 32'(done[i]), 32'd0);
               chk("idle_status", i, 32'(status[i]), 32'(fin_st[i]));
               chk("idle_acc_q", i, 32'(acc_q[i]), 32'(fin_acc[i]));
               chk("idle_instr_cnt", i, 32'(instr_cnt[i]), 32'(fin_cnt[i]));
            end
         end
      end
   end

   task automatic wr(input int addr, input logic [5:0] data);
      prog_we = 1'b1; prog_addr = 5'(addr); prog_data = data;
      img[addr] = data;
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   task automatic set_lit(input logic [7:0] a0, input logic [1:0] s0, input logic [7:0] c0,
                          input logic [7:0] a1, input logic [1:0] s1, input logic [7:0] c1);
      lit_en = 1'b1;
      lit_acc[0] = a0; lit_st[0] = s0; lit_cnt[0] = c0;
      lit_acc[1] = a1; lit_st[1] = s1; lit_cnt[1] = c1;
   endtask

   // Called one time unit after a rising edge while both instances are idle.
   task automatic run(input int len, input int hk, input bit bw, input bit hold);
      int c = 0;
      halt_at = hk; prog_len = 6'(len); start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      while (!(busy[0] == 1'b0 && busy[1] == 1'b0 && done[0] == 1'b0 && done[1] == 1'b0)) begin
         if (c >= 1200) begin to_flag = 1'b1; break; end
         halt_req = (hk >= 0 && c == 2 * hk + 1);
         prog_we = bw && (c == 1);
         if (bw && c == 1) begin prog_addr = 5'd0; prog_data = 6'b100111; end
         @(posedge clk); #1;
         c++;
      end
      halt_req = 1'b0; prog_we = 1'b0;
   endtask

   initial begin
      int len, hk;
      rst = 1'b1; prog_we = 1'b0; start = 1'b0; halt_req = 1'b0;
      prog_addr = '0; prog_data = '0; prog_len = '0;
      halt_at = -1; to_flag = 1'b0; lit_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      wr(0, 6'b100101); wr(1, 6'b001001); wr(2, 6'b100011); wr(3, 6'b010001);
      set_lit(8'h08, ST_END, 8'd4, 8'h08, ST_END, 8'd4);
      run(4, -1, 1'b0, 1'b0);

      wr(0, 6'b100001); wr(1, 6'b000001);
      set_lit(8'hFE, ST_END, 8'd2, 8'hFE, ST_END, 8'd2);
      run(2, -1, 1'b0, 1'b0);
      run(2, -1, 1'b0, 1'b1);
      run(2, -1, 1'b0, 1'b0);

      wr(0, 6'b100011); wr(1, 6'b001000); wr(2, 6'b100001); wr(3, 6'b011000);
      halt_req = 1'b1;
      @(posedge clk); #1 halt_req = 1'b0;
      set_lit(8'h01, ST_TIMEOUT, 8'd16, 8'h01, ST_TIMEOUT, 8'd255);
      run(4, -1, 1'b0, 1'b0);

      set_lit(8'h01, ST_HALT, 8'd7, 8'h01, ST_HALT, 8'd7);
      run(4, 6, 1'b1, 1'b0);
      set_lit(8'h03, ST_END, 8'd1, 8'h03, ST_END, 8'd1);
      run(1, -1, 1'b0, 1'b0);

      set_lit(8'h00, ST_END, 8'd0, 8'h00, ST_END, 8'd0);
      run(0, -1, 1'b0, 1'b0);

      wr(0, 6'b100101); wr(1, 6'b001001); wr(2, 6'b100011); wr(3, 6'b010001);
      lit_en = 1'b0;
      prog_len = 6'd4; halt_at = -1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); #1;
      set_lit(8'h08, ST_END, 8'd4, 8'h08, ST_END, 8'd4);
      run(4, -1, 1'b0, 1'b0);

      lit_en = 1'b0;
      for (int r = 0; r < 20; r++) begin
         len = int'($urandom_range(0, 32));
         for (int a = 0; a < len; a++) wr(a, 6'($urandom));
         hk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : -1;
         run(len, hk, 1'b0, 1'b0);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
